instr_fetch: RTL
================

# instr_fetch

Instruction fetch and issue sequencer that produces the machine-code stream consumed by the control decoder. It holds the program counter, reads a synchronous instruction ROM, and presents each instruction to the decode stage over a valid/ready handshake. It applies taken-branch redirects and stops on a HALT encoding. It sits between instruction memory and the decode/control stage of the core.

## Interface
- PW, 10, program counter and instruction-address width
- IW, 9, instruction width
- HALT_INSTR, {IW{1'b1}}, encoding that terminates execution
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins execution at start_addr (honoured only in IDLE or DONE)
- start_addr  in  PW  first instruction address
- imem_addr  out  PW  instruction ROM address, registered
- imem_rd  out  1  ROM read strobe
- imem_rdata  in  IW  ROM data, valid the cycle after imem_rd
- instr  out  IW  instruction presented to decode
- instr_valid  out  1  instr and pc_out are valid
- instr_ready  in  1  decode accepts instr this cycle
- pc_out  out  PW  address of presented instruction
- branch  in  1  taken branch; sampled only on an accept cycle
- branch_target  in  PW  redirect address, sampled with branch
- done  out  1  HALT accepted; held until next start or reset
- icount  out  16  instructions accepted since last start

## Operation
- States: IDLE, REQ, WAIT, ISSUE, DONE.
- IDLE: outputs quiet. On start: pc <= start_addr, icount <= 0, done <= 0, go to REQ.
- REQ: imem_addr = pc, imem_rd = 1 for exactly this cycle. Go to WAIT.
- WAIT: imem_rd = 0. At the end of the cycle, latch imem_rdata into instr and pc into pc_out. Go to ISSUE.
- ISSUE: instr_valid = 1. instr and pc_out stay stable until accepted.
  - Accept is instr_valid && instr_ready. On accept, icount increments; it saturates at 16'hFFFF.
  - If accepted instr == HALT_INSTR: go to DONE. branch is ignored.
  - Else if branch: pc <= branch_target, go to REQ.
  - Else: pc <= pc + 1 modulo 2^PW (wraps 2^PW-1 to 0), go to REQ.
- DONE: done = 1, instr_valid = 0. On start, behave as from IDLE.
- start in REQ, WAIT or ISSUE is ignored.
- branch and branch_target are ignored outside accept cycles.
- reset is asynchronous at any time, including mid-fetch. All registers clear and the state returns to IDLE. An in-flight ROM read is discarded.
- Reset values: imem_addr 0, imem_rd 0, instr 0, instr_valid 0, pc_out 0, done 0, icount 0, pc 0.

## Timing
- All outputs are registered.
- start high at edge N: imem_rd high in cycle N+1 (REQ), data latched at edge N+2 (WAIT), instr_valid high from cycle N+3.
- Minimum three cycles per instruction (REQ, WAIT, ISSUE) with instr_ready held high.
- Each stall cycle (instr_ready low in ISSUE) adds one cycle. instr and pc_out do not change while stalled.
- Accept at edge M: instr_valid low in cycle M+1 (REQ); next instr_valid from cycle M+3.
- A branch redirect costs no extra cycles compared with sequential flow.
- HALT accepted at edge M: done high from cycle M+1, and imem_rd stays low.

## Test plan
- Reset, then start with start_addr=0 and ROM[0..2]=9'h011, 9'h022, HALT; instr_ready=1 → instr sequence 011 (pc 0), 022 (pc 1), 1FF (pc 2). done high 9 cycles after start. icount=3. No ROM read after address 2.
- Stall: hold instr_ready=0 for 4 cycles on the first instruction → instr=9'h011 and pc_out=0 stay stable, imem_rd stays 0 and icount stays 0 during the stall; the second fetch begins the cycle after accept.
- Branch: accept pc 5 with branch=1, branch_target=10'h3F0 → next imem_addr=3F0 and next pc_out=3F0. Also drive branch=1 while not accepting → no effect.
- Wrap: start_addr=10'h3FF with ROM[3FF] non-HALT → next fetch address is 0.
- Reset mid-operation: assert reset during WAIT → all outputs 0 immediately (asynchronous) and state IDLE. A later start from start_addr=4 fetches address 4 with icount restarting at 0.
- Restart and ignored start: pulse start during ISSUE → ignored. After DONE, start at address 7 → done clears, icount=0, fetch of address 7.

Source files
------------

// File: rtl/instr_fetch.sv
// Fetch/issue sequencer: PC, synchronous ROM read, valid/ready issue to decode, branch redirect, HALT stop.
// Three cycles per instruction (REQ, WAIT, ISSUE); stalls in ISSUE holding instr/pc_out while instr_ready is low.
module instr_fetch #(
   parameter int            PW         = 10,
   parameter int            IW         = 9,
   parameter logic [IW-1:0] HALT_INSTR = {IW{1'b1}}
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [PW-1:0] start_addr,
   output logic [PW-1:0] imem_addr,
   output logic          imem_rd,
   input  logic [IW-1:0] imem_rdata,
   output logic [IW-1:0] instr,
   output logic          instr_valid,
   input  logic          instr_ready,
   output logic [PW-1:0] pc_out,
   input  logic          branch,
   input  logic [PW-1:0] branch_target,
   output logic          done,
   output logic [15:0]   icount
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_ISSUE,
      S_DONE
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [PW-1:0] pc;
   logic [PW-1:0] pc_nxt;
   logic          accept;
   logic          is_halt;
   logic          start_ok;
   logic          imem_rd_nxt;
   logic          instr_valid_nxt;
   logic          done_nxt;

   assign accept   = instr_valid & instr_ready;
   assign is_halt  = (instr == HALT_INSTR);
   assign start_ok = start & ((state == S_IDLE) | (state == S_DONE));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_REQ;
         S_DONE:  if (start) state_nxt = S_REQ;
         S_REQ:   state_nxt = S_WAIT;
         S_WAIT:  state_nxt = S_ISSUE;
         S_ISSUE: if (accept) state_nxt = is_halt ? S_DONE : S_REQ;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output flags are decoded from the next state so they come straight out of flops.
   always_comb begin
      imem_rd_nxt     = (state_nxt == S_REQ);
      instr_valid_nxt = (state_nxt == S_ISSUE);
      done_nxt        = (state_nxt == S_DONE);
   end

   always_comb begin
      pc_nxt = pc;
      if (start_ok) begin
         pc_nxt = start_addr;
      end else if (accept && !is_halt) begin
         pc_nxt = branch ? branch_target : pc + PW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= '0;
         imem_addr   <= '0;
         imem_rd     <= 1'b0;
         instr       <= '0;
         instr_valid <= 1'b0;
         pc_out      <= '0;
         done        <= 1'b0;
         icount      <= '0;
      end else begin
         pc          <= pc_nxt;
         imem_rd     <= imem_rd_nxt;
         instr_valid <= instr_valid_nxt;
         done        <= done_nxt;
         if (state_nxt == S_REQ) begin
            imem_addr <= pc_nxt;
         end
         if (state == S_WAIT) begin
            instr  <= imem_rdata;
            pc_out <= pc;
         end
         if (start_ok) begin
            icount <= '0;
         end else if (accept && (icount != 16'hFFFF)) begin
            icount <= icount + 16'd1;
         end
      end
   end

endmodule
